// File: rtl/ex_stage_if.sv
// Execute-stage bus: decoded operands from id in, write-back result, HI/LO and stall out.
interface ex_stage_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned SEL_W  = 3;

    logic [OP_W-1:0]   aluop_i;
    logic [SEL_W-1:0]  alusel_i;
    logic [DATA_W-1:0] reg1_data_i;
    logic [DATA_W-1:0] reg2_data_i;
    logic [ADDR_W-1:0] waddr_i;
    logic              wreg_i;
    logic              wreg_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] wdata_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic              stall_req_o;

    modport master (
        output aluop_i, alusel_i, reg1_data_i, reg2_data_i, waddr_i, wreg_i,
        input  wreg_o, waddr_o, wdata_o, hi_o, lo_o, stall_req_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_data_i, reg2_data_i, waddr_i, wreg_i,
        output wreg_o, waddr_o, wdata_o, hi_o, lo_o, stall_req_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move results, HI/LO ownership, iterative shift-add MULT/MULTU.
// Define EX_FAST_MUL_EN for a single-cycle multiplier (no stall, BITS_PER_STEP ignored).
module ex_stage #(
    parameter int unsigned BITS_PER_STEP = 1
) (
    input logic        clk,
    input logic        rst,
    ex_stage_if.slave  ex
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [7:0] OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    logic [7:0]        op_q;
    logic [2:0]        sel_q;
    logic [DATA_W-1:0] r1_q;
    logic [DATA_W-1:0] r2_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              wreg_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              stall;

    // Stage register: follows id unless the multiplier holds it
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_NOP;
            sel_q   <= SEL_NOP;
            r1_q    <= '0;
            r2_q    <= '0;
            waddr_q <= '0;
            wreg_q  <= 1'b0;
        end else if (!stall) begin
            op_q    <= ex.aluop_i;
            sel_q   <= ex.alusel_i;
            r1_q    <= ex.reg1_data_i;
            r2_q    <= ex.reg2_data_i;
            waddr_q <= ex.waddr_i;
            wreg_q  <= ex.wreg_i;
        end
    end

    logic [DATA_W-1:0] result;
    logic              wr_en;

    always_comb begin
        result = '0;
        wr_en  = wreg_q;
        case (sel_q)
            SEL_LOGIC: begin
                case (op_q)
                    OP_OR:   result = r1_q | r2_q;
                    OP_AND:  result = r1_q & r2_q;
                    OP_XOR:  result = r1_q ^ r2_q;
                    OP_NOR:  result = ~(r1_q | r2_q);
                    default: result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (op_q)
                    OP_SLL:  result = r2_q << r1_q[4:0];
                    OP_SRL:  result = r2_q >> r1_q[4:0];
                    OP_SRA:  result = DATA_W'($signed(r2_q) >>> r1_q[4:0]);
                    default: result = '0;
                endcase
            end
            SEL_MOVE: begin
                case (op_q)
                    OP_MFHI:          result = hi_q;
                    OP_MFLO:          result = lo_q;
                    OP_MOVN, OP_MOVZ: result = r1_q;
                    default:          result = '0;
                endcase
            end
            default: wr_en = 1'b0;
        endcase
        // HI/LO writers never target the register file
        if (op_q == OP_MTHI || op_q == OP_MTLO || op_q == OP_MULT || op_q == OP_MULTU)
            wr_en = 1'b0;
    end

    assign ex.wreg_o  = wr_en;
    assign ex.waddr_o = waddr_q;
    assign ex.wdata_o = result;
    assign ex.hi_o    = hi_q;
    assign ex.lo_o    = lo_q;

`ifdef EX_FAST_MUL_EN
    logic              fast_signed;
    logic [63:0]       fast_a;
    logic [63:0]       fast_b;
    logic [63:0]       fast_prod;

    // Sign-extend for MULT; low 64 bits of the 64x64 product are exact
    assign fast_signed = (op_q == OP_MULT);
    assign fast_a      = {{32{fast_signed & r1_q[31]}}, r1_q};
    assign fast_b      = {{32{fast_signed & r2_q[31]}}, r2_q};
    assign fast_prod   = fast_a * fast_b;
    assign stall       = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (op_q == OP_MTHI) hi_q <= r1_q;
            if (op_q == OP_MTLO) lo_q <= r1_q;
            if (op_q == OP_MULT || op_q == OP_MULTU) {hi_q, lo_q} <= fast_prod;
        end
    end
`else
    localparam int unsigned NSTEP = DATA_W / BITS_PER_STEP;
    localparam int unsigned CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       acc;
    logic [63:0]       mcand;
    logic [DATA_W-1:0] mplier;
    logic              neg;
    logic [63:0]       partial;
    logic [63:0]       prod;
    logic              load_mul;
    logic              is_signed;
    logic [DATA_W-1:0] op1_mag;
    logic [DATA_W-1:0] op2_mag;
    logic              done;

    assign is_signed = (ex.aluop_i == OP_MULT);
    assign load_mul  = !stall && (ex.aluop_i == OP_MULT || ex.aluop_i == OP_MULTU);
    assign op1_mag   = (is_signed && ex.reg1_data_i[31]) ? DATA_W'(-ex.reg1_data_i) : ex.reg1_data_i;
    assign op2_mag   = (is_signed && ex.reg2_data_i[31]) ? DATA_W'(-ex.reg2_data_i) : ex.reg2_data_i;
    assign stall     = (state == BUSY) && (cnt != CNT_LAST);
    assign done      = (state == BUSY) && (cnt == CNT_LAST);

    // Partial product for the low BITS_PER_STEP multiplier bits
    always_comb begin
        partial = '0;
        for (int b = 0; b < int'(BITS_PER_STEP); b++) begin
            if (mplier[b]) partial = partial + (mcand << b);
        end
    end

    assign prod = acc + partial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            if (state == BUSY) begin
                acc    <= prod;
                mcand  <= mcand << BITS_PER_STEP;
                mplier <= mplier >> BITS_PER_STEP;
                cnt    <= cnt + CNT_W'(1);
                if (cnt == CNT_LAST) state <= IDLE;
            end
            // Back-to-back multiplies reload on the completing edge
            if (load_mul) begin
                state  <= BUSY;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {32'b0, op1_mag};
                mplier <= op2_mag;
                neg    <= is_signed & (ex.reg1_data_i[31] ^ ex.reg2_data_i[31]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (op_q == OP_MTHI) hi_q <= r1_q;
            if (op_q == OP_MTLO) lo_q <= r1_q;
            if (done) {hi_q, lo_q} <= neg ? 64'(-prod) : prod;
        end
    end
`endif

    assign ex.stall_req_o = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: scoreboarded write-back results plus HI/LO/stall checks.
module tb_ex_stage;
    localparam logic [7:0] OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

`ifdef EX_FAST_MUL_EN
    localparam int STALLS = 0;
`else
    localparam int STALLS = 31;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [37:0] exp_q[$];
    string       tag_q[$];

    ex_stage_if bus ();

    ex_stage #(.BITS_PER_STEP(1)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wa, input logic we);
        bus.aluop_i     = op;
        bus.alusel_i    = sel;
        bus.reg1_data_i = r1;
        bus.reg2_data_i = r2;
        bus.waddr_i     = wa;
        bus.wreg_i      = we;
    endtask

    // Issue one instruction, expect its result the cycle after it loads
    task automatic issue(input string tag, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wa,
                         input logic we, input logic exp_we, input logic [31:0] exp_data);
        logic [37:0] e;
        string       t;
        drive(op, sel, r1, r2, wa, we);
        exp_q.push_back({exp_we, wa, exp_data});
        tag_q.push_back(tag);
        @(posedge clk); #1;
        drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 64'({bus.wreg_o, bus.waddr_o, bus.wdata_o}), 64'(e));
    endtask

    task automatic wait_stall(input string tag, input int expected);
        int n = 0;
        while (bus.stall_req_o === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check(tag, 64'(n), 64'(expected));
    endtask

    initial begin
        drive(OP_NOP, SEL_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_wb", 64'({bus.wreg_o, bus.waddr_o, bus.wdata_o}), 64'(0));
        check("rst_stall", 64'(bus.stall_req_o), 64'(0));
        check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'(0));

        issue("or",   OP_OR,  SEL_LOGIC, 32'h0000_F0F0, 32'h1234_0000, 5'd3, 1'b1, 1'b1, 32'h1234_F0F0);
        issue("and",  OP_AND, SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd4, 1'b1, 1'b1, 32'h0F00_0F00);
        issue("xor",  OP_XOR, SEL_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 5'd5, 1'b1, 1'b1, 32'h5555_5555);
        issue("nor",  OP_NOR, SEL_LOGIC, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 32'hFFFF_FFFF);
        issue("sra",  OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd7, 1'b1, 1'b1, 32'hF800_0001);
        issue("srl",  OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd8, 1'b1, 1'b1, 32'h0800_0001);
        issue("sll",  OP_SLL, SEL_SHIFT, 32'd31, 32'h1, 5'd9, 1'b1, 1'b1, 32'h8000_0000);
        issue("movn", OP_MOVN, SEL_MOVE, 32'hCAFE_0001, 32'h1, 5'd10, 1'b1, 1'b1, 32'hCAFE_0001);
        issue("badsel", OP_OR, 3'b111, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 1'b0, 32'h0);

        issue("mtlo", OP_MTLO, SEL_NOP, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0);
        issue("mflo", OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd11, 1'b1, 1'b1, 32'hDEAD_BEEF);
        issue("mthi", OP_MTHI, SEL_NOP, 32'h1357_9BDF, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
        issue("mfhi", OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd12, 1'b1, 1'b1, 32'h1357_9BDF);

        issue("mult_wb", OP_MULT, SEL_NOP, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0, 1'b0, 32'h0);
        wait_stall("mult_stall_cycles", STALLS);
        issue("mult_mfhi", OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd13, 1'b1, 1'b1, 32'hFFFF_FFFF);
        check("mult_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);

        issue("multu_wb", OP_MULTU, SEL_NOP, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0, 1'b0, 32'h0);
        wait_stall("multu_stall_cycles", STALLS);
        issue("multu_mfhi", OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 5'd14, 1'b1, 1'b1, 32'h0000_0002);
        check("multu_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0002_FFFF_FFFA);

        issue("b2b_first", OP_MULT, SEL_NOP, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b0, 1'b0, 32'h0);
        wait_stall("b2b_first_stall", STALLS);
        issue("b2b_second", OP_MULTU, SEL_NOP, 32'd7, 32'd6, 5'd0, 1'b0, 1'b0, 32'h0);
        check("b2b_first_hilo", {bus.hi_o, bus.lo_o}, 64'h4000_0000_0000_0000);
        check("b2b_second_busy", 64'(bus.stall_req_o), 64'(STALLS != 0));
        wait_stall("b2b_second_stall", STALLS);
        issue("b2b_mflo", OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 5'd15, 1'b1, 1'b1, 32'd42);
        check("b2b_second_hilo", {bus.hi_o, bus.lo_o}, 64'd42);

        issue("abort_mult", OP_MULT, SEL_NOP, 32'd5, 32'd5, 5'd0, 1'b0, 1'b0, 32'h0);
        repeat (10) begin @(posedge clk); #1; end
        check("abort_busy", 64'(bus.stall_req_o), 64'(STALLS != 0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_stall", 64'(bus.stall_req_o), 64'(0));
        check("abort_hilo", {bus.hi_o, bus.lo_o}, 64'(0));
        check("abort_wb", 64'({bus.wreg_o, bus.waddr_o, bus.wdata_o}), 64'(0));
        repeat (40) begin @(posedge clk); #1; end
        check("abort_no_commit", {bus.hi_o, bus.lo_o}, 64'(0));
        check("abort_idle", 64'(bus.stall_req_o), 64'(0));

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
